product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
//
// PURPOSE
//   Downstream consumer of the 2-bit binary multiplier. Accepts a stream of
//   products over a valid/ready handshake and sums LEN consecutive products
//   into one frame result. Presents the result over a valid/ready output and
//   flags overflow. Used as the accumulate stage of a multiply-accumulate path.
//
// PARAMETERS
//   PROD_W  4  width of incoming product (multiplier output C[3:0])
//   ACC_W   8  accumulator / result width; must satisfy ACC_W >= PROD_W
//   LEN     4  products per frame; must satisfy LEN >= 1
//
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   clear      in   1       synchronous abort: discard frame, return to ACC
//   in_valid   in   1       in_prod valid this cycle
//   in_ready   out  1       accumulator can accept a product this cycle
//   in_prod    in   PROD_W  unsigned product from multiplier
//   out_valid  out  1       out_sum/out_ovf hold a completed frame
//   out_ready  in   1       consumer takes the frame this cycle
//   out_sum    out  ACC_W   frame total
//   out_ovf    out  1       frame total exceeded 2^ACC_W-1
//
// BEHAVIOUR
//   - States: ACC (accepting products), HOLD (presenting result).
//   - Reset (async on rst_n low): state=ACC, acc=0, count=0, out_valid=0,
//     out_sum=0, out_ovf=0. in_ready=(state==ACC), so in_ready=1 after reset.
//   - Accept: in_valid & in_ready. Add zero-extended in_prod to acc; count+1.
//     count width $clog2(LEN+1).
//   - Last accept (count==LEN-1): register final sum into out_sum, set
//     out_valid, go HOLD. Latency: out_valid rises the cycle after the last
//     accept. LEN=1: each accepted product is a frame.
//   - HOLD: in_ready=0. out_sum/out_ovf stay stable while out_valid &
//     !out_ready. On out_valid & out_ready: clear out_valid; acc=0, count=0,
//     out_ovf=0; return to ACC. in_ready rises the following cycle, so there
//     is no accept in the handoff cycle.
//   - Overflow: any add with carry out of ACC_W bits sets a sticky frame
//     overflow bit. That bit is copied to out_ovf with the result.
//   - clear has priority over every event, including a same-cycle last
//     accept or output handshake. Effect: state=ACC, acc=0, count=0,
//     out_valid=0, out_ovf=0. out_sum keeps its last value and is
//     don't-care while out_valid=0.
//   - in_prod and in_valid are ignored while in_ready=0.
//   - Reset mid-frame: the partial frame is lost; state returns to reset values.
//
// CONFIGURATION
//   PROD_ACC_SAT_EN defined: saturating add. On overflow acc clamps to
//     {ACC_W{1'b1}} and stays there for the rest of the frame; out_ovf=1.
//   PROD_ACC_SAT_EN undefined: wrapping add (mod 2^ACC_W); out_ovf=1 marks
//     that wrap occurred.
//
// TESTING
//   1. LEN=4, ACC_W=8, out_ready=1. Products 9,6,4,1 back-to-back
//      -> out_valid one cycle after 4th accept; out_sum=20, out_ovf=0.
//   2. Same frame with out_ready=0 for 5 cycles -> out_valid and out_sum=20
//      held stable, in_ready=0 throughout. Release out_ready -> handshake,
//      then in_ready=1 next cycle.
//   3. ACC_W=5, LEN=4, products 9,9,9,9 -> out_ovf=1. out_sum=4 without
//      PROD_ACC_SAT_EN; out_sum=31 with PROD_ACC_SAT_EN.
//   4. in_valid toggled 1,0,1,0 with products 3,2,3,2 -> only valid cycles
//      are counted; out_sum=10 after the 4th accept.
//   5. clear after 2 accepts, then 4,4,4,4 -> out_sum=16. clear in the same
//      cycle as the output handshake -> out_valid=0 and no extra frame.
//   6. rst_n pulsed low mid-frame (asynchronous to clk) -> all outputs reach
//      reset values immediately. Next 4 products form a fresh frame.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums LEN consecutive products per frame and presents the total over valid/ready.
// Optional define PROD_ACC_SAT_EN selects a saturating add instead of a wrapping add.
module product_accumulator #(
  parameter int unsigned PROD_W = 4,
  parameter int unsigned ACC_W  = 8,
  parameter int unsigned LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_add;
  logic             ovf_add;
  logic             last;

  // Extra top bit of the widened sum is the carry out of the accumulator.
  assign sum_ext = {1'b0, acc_q} + SUM_W'(in_prod);
  assign ovf_add = ovf_q | sum_ext[ACC_W];
`ifdef PROD_ACC_SAT_EN
  assign acc_add = ovf_add ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif
  assign last = (cnt_q == CNT_W'(LEN - 1));

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Next state; clear overrides any accept or handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d = acc_add;
            ovf_d = ovf_add;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
              out_sum_d   = acc_add;
              out_ovf_d   = ovf_add;
              out_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_ovf_d   = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: an 8-bit and a 5-bit accumulator
// share one directed stimulus stream; a monitor checks each handed-off frame.
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_prod;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_sum8;
  logic       in_ready5, out_valid5, out_ovf5;
  logic [4:0] out_sum5;

  int tests = 0;
  int fails = 0;

  int q8_sum[$];
  int q8_ovf[$];
  int q5_sum[$];
  int q5_ovf[$];

`ifdef PROD_ACC_SAT_EN
  localparam int OVF5_SUM = 31;
`else
  localparam int OVF5_SUM = 4;
`endif

  product_accumulator #(.PROD_W(4), .ACC_W(8), .LEN(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready8), .in_prod(in_prod),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_ovf(out_ovf8)
  );

  product_accumulator #(.PROD_W(4), .ACC_W(5), .LEN(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready5), .in_prod(in_prod),
    .out_valid(out_valid5), .out_ready(out_ready),
    .out_sum(out_sum5), .out_ovf(out_ovf5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int s8, input int o8, input int s5, input int o5);
    q8_sum.push_back(s8);
    q8_ovf.push_back(o8);
    q5_sum.push_back(s5);
    q5_ovf.push_back(o5);
  endtask

  // Present one product and hold it until the edge that accepts it.
  task automatic send(input logic [3:0] p);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every completed handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && !clear && out_ready) begin
      if (out_valid8) begin
        if (q8_sum.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_frame8: got sum %0d, required no frame", out_sum8);
        end else begin
          chk("sum8", 32'(out_sum8), 32'(q8_sum.pop_front()));
          chk("ovf8", 32'(out_ovf8), 32'(q8_ovf.pop_front()));
        end
      end
      if (out_valid5) begin
        if (q5_sum.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_frame5: got sum %0d, required no frame", out_sum5);
        end else begin
          chk("sum5", 32'(out_sum5), 32'(q5_sum.pop_front()));
          chk("ovf5", 32'(out_ovf5), 32'(q5_ovf.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = 4'd0;
    out_ready = 1'b1;

    #2;
    chk("rst_valid8", 32'(out_valid8), 32'd0);
    chk("rst_sum8",   32'(out_sum8),   32'd0);
    chk("rst_ovf8",   32'(out_ovf8),   32'd0);
    chk("rst_ready8", 32'(in_ready8),  32'd1);
    chk("rst_ready5", 32'(in_ready5),  32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame, back-to-back accepts, latency of out_valid.
    push_frame(20, 0, 20, 0);
    send(4'd9); send(4'd6); send(4'd4);
    chk("t1_valid_early", 32'(out_valid8), 32'd0);
    send(4'd1);
    chk("t1_valid_latency", 32'(out_valid8), 32'd1);
    chk("t1_ready_hold",    32'(in_ready8),  32'd0);
    cyc();
    chk("t1_valid_after", 32'(out_valid8), 32'd0);
    chk("t1_ready_after", 32'(in_ready8),  32'd1);

    // Backpressure: result held, input ignored while held.
    out_ready = 1'b0;
    push_frame(20, 0, 20, 0);
    send(4'd9); send(4'd6); send(4'd4); send(4'd1);
    in_valid = 1'b1;
    in_prod  = 4'd15;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_valid_hold", 32'(out_valid8), 32'd1);
      chk("t2_sum_hold",   32'(out_sum8),   32'd20);
      chk("t2_sum5_hold",  32'(out_sum5),   32'd20);
      chk("t2_ready_hold", 32'(in_ready8),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("t2_valid_after", 32'(out_valid8), 32'd0);
    chk("t2_ready_after", 32'(in_ready8),  32'd1);

    // Overflow on the 5-bit accumulator only.
    push_frame(36, 0, OVF5_SUM, 1);
    send(4'd9); send(4'd9); send(4'd9); send(4'd9);
    cyc();

    // Gapped in_valid; garbage product on invalid cycles.
    push_frame(10, 0, 10, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_prod  = (i % 2 == 0) ? 4'd3 : 4'd2;
      cyc();
      in_valid = 1'b0;
      in_prod  = 4'd15;
      cyc();
    end
    chk("t4_valid_after", 32'(out_valid8), 32'd0);

    // Clear mid-frame discards the partial sum.
    send(4'd7); send(4'd7);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t5_clear_valid", 32'(out_valid8), 32'd0);
    push_frame(16, 0, 16, 0);
    send(4'd4); send(4'd4); send(4'd4); send(4'd4);
    cyc();

    // Clear in the handshake cycle drops the frame.
    out_ready = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    chk("t5_hold_valid", 32'(out_valid8), 32'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t5_clr_hs_valid", 32'(out_valid8), 32'd0);
    chk("t5_clr_hs_ready", 32'(in_ready8),  32'd1);
    repeat (3) cyc();
    chk("t5_no_extra", 32'(out_valid8), 32'd0);

    // Asynchronous reset mid-frame.
    send(4'd5); send(4'd5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid8", 32'(out_valid8), 32'd0);
    chk("t6_rst_sum8",   32'(out_sum8),   32'd0);
    chk("t6_rst_sum5",   32'(out_sum5),   32'd0);
    chk("t6_rst_ovf5",   32'(out_ovf5),   32'd0);
    chk("t6_rst_ready8", 32'(in_ready8),  32'd1);
    #4 rst_n = 1'b1;
    cyc();
    push_frame(10, 0, 10, 0);
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    cyc();
    chk("t6_valid_after", 32'(out_valid8), 32'd0);

    repeat (2) cyc();
    chk("q8_drained", 32'(q8_sum.size()), 32'd0);
    chk("q5_drained", 32'(q5_sum.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
